lcd_hd44780_responder: RTL and testbench
========================================

// Module: lcd_hd44780_responder
// PURPOSE
//  Receiving end of the HD44780-style 8-bit LCD bus (rs/rw/en/data) driven by the washing-machine LCD writer.
//  Decodes instructions, keeps a character buffer (DDRAM), cursor and display flags, and models the busy period.
//  Used on-chip as a display-side mirror for an alternate output or scanner, and in benches as a protocol checker for the LCD writer.
// PARAMETERS
//  DDRAM_DEPTH        32    characters stored; power of 2; AW = $clog2(DDRAM_DEPTH)
//  CMD_BUSY_CYCLES    40    clk cycles busy after any write except clear
//  CLEAR_BUSY_CYCLES  1500  clk cycles busy after clear (0x01); must be >= DDRAM_DEPTH
// PORTS
//  clk           in   1   clock
//  reset         in   1   reset, asynchronous, active-high
//  lcd_rs        in   1   0=instruction, 1=data
//  lcd_rw        in   1   0=write, 1=read
//  lcd_en        in   1   enable strobe (async to clk)
//  lcd_data_in   in   8   bus from writer
//  lcd_data_out  out  8   read data (LCD_READ_EN only, else 0)
//  lcd_data_oe   out  1   drive enable for lcd_data_out
//  busy          out  1   busy flag
//  display_on    out  1   D bit of display control
//  cursor_addr   out  AW  current DDRAM address
//  rd_addr       in   AW  scanner read address
//  rd_char       out  8   DDRAM[rd_addr], 1-cycle latency
//  write_strobe  out  1   1-cycle pulse per accepted data write
//  protocol_err  out  1   1-cycle pulse per rejected transaction
// BEHAVIOUR
//  Reset values: busy=0, display_on=0, cursor_addr=0, incr=1, lcd_data_oe=0, lcd_data_out=0, write_strobe=0, protocol_err=0, FSM=UNINIT.
//  DDRAM is not reset; contents are undefined until the first clear.
//  Capture: lcd_en passes through a 2-FF synchroniser; rs/rw/data are delayed by the same 2 stages.
//  A transaction is the synchronised 1->0 edge of en; the bus is sampled that cycle.
//  Effects (flags, DDRAM write, busy=1) appear the next cycle.
//  FSM: UNINIT -> READY on write 0x38-class (001x_xxxx with DL bit4=1).
//   In UNINIT, every other transaction pulses protocol_err and is ignored.
//   READY -> BUSY on any accepted write; BUSY counts down and returns to READY when the counter reaches 0.
//   CLEAR is a BUSY sub-mode: writes 8'h20 to addresses 0..DEPTH-1, one per cycle.
//  Writes while BUSY: dropped, protocol_err pulsed, counter not restarted.
//  Instruction decode, by highest set bit:
//   1aaa_aaaa       cursor_addr <= a mod DEPTH
//   01xx_xxxx       CGRAM set: accepted, no effect
//   001d_xxxx       function set; d=0 pulses protocol_err, no state change
//   0001_sr00       s=0: cursor +1 (r=1) or -1 (r=0) with wrap; s=1: no effect
//   0000_1dcb       display_on <= d; c and b ignored
//   0000_01is       incr <= i; s ignored
//   0000_001x       cursor_addr <= 0
//   0000_0001       clear: fill, cursor_addr <= 0, incr <= 1, busy for CLEAR_BUSY_CYCLES
//   0000_0000       no-op; still busy CMD_BUSY_CYCLES
//  Data write (rs=1, rw=0): DDRAM[cursor_addr] <= data; write_strobe pulses; cursor_addr +/-1 per incr.
//   Wraps DEPTH-1 -> 0 and 0 -> DEPTH-1.
//  rd port: synchronous, read-first; a same-cycle write to rd_addr returns old data.
//  Reset mid-operation: busy drops, any fill aborts, FSM returns to UNINIT.
// CONFIGURATION
//  LCD_READ_EN defined: a rw=1, rs=0 transaction drives lcd_data_oe=1 while synchronised en is high.
//   lcd_data_out = {busy, cursor_addr zero-extended to 7 bits}. Reads are legal when BUSY and do not change state.
//   rs=1 reads pulse protocol_err.
//  LCD_READ_EN undefined: every rw=1 transaction pulses protocol_err; lcd_data_oe and lcd_data_out are tied to 0.
// STRUCTURE
//  Package lcd_hd44780_pkg: opcode masks/values, FSM state enum, CHAR_SPACE=8'h20, BF_BIT=7, FUNC_DL_BIT=4.
//  Sub-module lcd_ddram: DEPTH x 8 memory, one write port and one synchronous read-first read port.
//  Top level holds the synchroniser, edge detect, decoder, FSM, busy counter and clear-fill address.
// TESTING
//  1. Reset, then writes 0x38, 0x0C, 0x01, 0x06 with 2000-cycle gaps -> display_on=1, cursor_addr=0, rd_char=0x20 at all 32 addresses, protocol_err never asserted.
//  2. After step 1, data "WASHINZ" at 100-cycle gaps -> rd 0..6 = 57 41 53 48 49 4E 5A; cursor_addr=7; 7 write_strobe pulses.
//  3. Instruction 0x9F, then data 'A' and 'B' -> DDRAM[31]=0x41, DDRAM[0]=0x42, cursor_addr=1.
//  4. Second data write 5 cycles after the first -> protocol_err pulse; DDRAM and cursor reflect only the first write.
//  5. Data 0x41 before any 0x38 -> protocol_err, FSM stays UNINIT. Reset asserted 10 cycles into a clear -> busy=0 next cycle, UNINIT.
//  6. LCD_READ_EN: rs=0 rw=1 read 3 cycles after a data write at addr 4 -> data_out=0x85, oe high only while en high. Without the macro: protocol_err, oe=0.

Source files
------------

// File: rtl/lcd_hd44780_pkg.sv
// Shared definitions for the HD44780-style LCD bus responder.
// Contents: captured-bus struct, responder FSM state enum, instruction
// opcode masks/values, an instruction classifier, and bus constants.
package lcd_hd44780_pkg;

  // One sample of the writer-side bus, carried through the synchroniser.
  typedef struct packed {
    logic       en;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_bus_t;

  typedef enum logic [1:0] {
    ST_UNINIT = 2'd0,
    ST_READY  = 2'd1,
    ST_BUSY   = 2'd2,
    ST_CLEAR  = 2'd3
  } lcd_state_e;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_CLEAR   = 4'd1,
    OP_HOME    = 4'd2,
    OP_ENTRY   = 4'd3,
    OP_DISPLAY = 4'd4,
    OP_SHIFT   = 4'd5,
    OP_FUNC    = 4'd6,
    OP_CGRAM   = 4'd7,
    OP_DDRAM   = 4'd8
  } lcd_op_e;

  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam int         BF_BIT      = 7;
  localparam int         FUNC_DL_BIT = 4;

  // Instruction classes: each is "highest set bit" expressed as mask/value.
  localparam logic [7:0] OP_DDRAM_MASK   = 8'h80, OP_DDRAM_VAL   = 8'h80;
  localparam logic [7:0] OP_CGRAM_MASK   = 8'hC0, OP_CGRAM_VAL   = 8'h40;
  localparam logic [7:0] OP_FUNC_MASK    = 8'hE0, OP_FUNC_VAL    = 8'h20;
  localparam logic [7:0] OP_SHIFT_MASK   = 8'hF0, OP_SHIFT_VAL   = 8'h10;
  localparam logic [7:0] OP_DISPLAY_MASK = 8'hF8, OP_DISPLAY_VAL = 8'h08;
  localparam logic [7:0] OP_ENTRY_MASK   = 8'hFC, OP_ENTRY_VAL   = 8'h04;
  localparam logic [7:0] OP_HOME_MASK    = 8'hFE, OP_HOME_VAL    = 8'h02;
  localparam logic [7:0] OP_CLEAR_MASK   = 8'hFF, OP_CLEAR_VAL   = 8'h01;

  // Classify an instruction byte by its highest set bit.
  function automatic lcd_op_e decode_op(input logic [7:0] d);
    lcd_op_e op;
    if ((d & OP_DDRAM_MASK) == OP_DDRAM_VAL) begin
      op = OP_DDRAM;
    end else if ((d & OP_CGRAM_MASK) == OP_CGRAM_VAL) begin
      op = OP_CGRAM;
    end else if ((d & OP_FUNC_MASK) == OP_FUNC_VAL) begin
      op = OP_FUNC;
    end else if ((d & OP_SHIFT_MASK) == OP_SHIFT_VAL) begin
      op = OP_SHIFT;
    end else if ((d & OP_DISPLAY_MASK) == OP_DISPLAY_VAL) begin
      op = OP_DISPLAY;
    end else if ((d & OP_ENTRY_MASK) == OP_ENTRY_VAL) begin
      op = OP_ENTRY;
    end else if ((d & OP_HOME_MASK) == OP_HOME_VAL) begin
      op = OP_HOME;
    end else if ((d & OP_CLEAR_MASK) == OP_CLEAR_VAL) begin
      op = OP_CLEAR;
    end else begin
      op = OP_NOP;
    end
    return op;
  endfunction

endpackage

// File: rtl/lcd_hd44780_responder_ddram.sv
// Character buffer (DDRAM) for the LCD responder.
// Ports:
//   clk    in         clock
//   we     in         write enable
//   waddr  in  [AW]   write address
//   wdata  in  [8]    write data
//   raddr  in  [AW]   read address
//   rdata  out [8]    mem[raddr] one cycle later; a same-cycle write to
//                     raddr returns the old contents (read-first)
// The array is deliberately not reset; contents are undefined until the
// responder's clear-fill has run.
module lcd_ddram
  #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
  )
  (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
  );

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Write port and registered read-first read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Receiving end of an HD44780-style 8-bit LCD bus.
// Synchronises the writer's en strobe (and delays rs/rw/data to match),
// treats each synchronised falling edge of en as one transaction, decodes
// instructions and data writes, keeps cursor/display/entry flags, a DDRAM
// character buffer and a busy period.
// Ports:
//   clk, reset (async, active-high)
//   lcd_rs, lcd_rw, lcd_en, lcd_data_in   writer-side bus
//   lcd_data_out, lcd_data_oe             read-back bus (busy flag + address)
//   busy, display_on, cursor_addr         responder status
//   rd_addr / rd_char                     scanner port into DDRAM, 1-cycle latency
//   write_strobe                          pulse per accepted data write
//   protocol_err                          pulse per rejected transaction
// Build option: define LCD_READ_EN to support rs=0 rw=1 status reads;
// without it every read is rejected and the read-back bus is tied to 0.
module lcd_hd44780_responder
  import lcd_hd44780_pkg::*;
  #(
    parameter int DDRAM_DEPTH       = 32,
    parameter int CMD_BUSY_CYCLES   = 40,
    parameter int CLEAR_BUSY_CYCLES = 1500,
    parameter int AW                = $clog2(DDRAM_DEPTH)
  )
  (
    input  logic          clk,
    input  logic          reset,
    input  logic          lcd_rs,
    input  logic          lcd_rw,
    input  logic          lcd_en,
    input  logic [7:0]    lcd_data_in,
    output logic [7:0]    lcd_data_out,
    output logic          lcd_data_oe,
    output logic          busy,
    output logic          display_on,
    output logic [AW-1:0] cursor_addr,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_char,
    output logic          write_strobe,
    output logic          protocol_err
  );

  localparam int CW = $clog2(CLEAR_BUSY_CYCLES + 1);
  localparam logic [CW-1:0] CMD_LOAD   = CW'(CMD_BUSY_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_BUSY_CYCLES - 1);
  // The fill runs during the first DDRAM_DEPTH cycles of the clear period,
  // i.e. while the countdown is still at or above this threshold.
  localparam logic [CW-1:0] FILL_THRESH = CW'(CLEAR_BUSY_CYCLES - DDRAM_DEPTH);
  localparam logic [AW-1:0] ONE_A       = AW'(1);

  lcd_bus_t      sync1_d, sync1_q, sync2_d, sync2_q;
  logic          en_prev_d, en_prev_q;
  lcd_state_e    state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [AW-1:0] fill_d, fill_q;
  logic [AW-1:0] cursor_d, cursor_q;
  logic          incr_d, incr_q;
  logic          disp_d, disp_q;
  logic          busy_d, busy_q;
  logic          strobe_d, strobe_q;
  logic          err_d, err_q;

  logic          xact_s;
  lcd_op_e       op_s;
  logic [AW-1:0] cursor_step_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_waddr_s;
  logic [7:0]    mem_wdata_s;

  // Synchroniser inputs: stage 2 holds the bus as seen on the sampled edge.
  always_comb begin
    sync1_d   = '{en: lcd_en, rs: lcd_rs, rw: lcd_rw, data: lcd_data_in};
    sync2_d   = sync1_q;
    en_prev_d = sync2_q.en;
  end

  // Synchroniser and edge-detect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      en_prev_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      en_prev_q <= en_prev_d;
    end
  end

  assign xact_s        = en_prev_q & ~sync2_q.en;
  assign op_s          = decode_op(sync2_q.data);
  assign cursor_step_s = incr_q ? (cursor_q + ONE_A) : (cursor_q - ONE_A);

  // Next-state: busy countdown, clear fill, transaction decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    cursor_d    = cursor_q;
    incr_d      = incr_q;
    disp_d      = disp_q;
    strobe_d    = 1'b0;
    err_d       = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = cursor_q;
    mem_wdata_s = sync2_q.data;

    case (state_q)
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CLEAR: begin
        if (cnt_q >= FILL_THRESH) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = fill_q;
          mem_wdata_s = CHAR_SPACE;
          fill_d      = fill_q + ONE_A;
        end else begin
          fill_d = fill_q;
        end
        if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase

    if (xact_s) begin
      if (sync2_q.rw) begin
`ifdef LCD_READ_EN
        // Status reads are side-effect free; data reads are not supported.
        err_d = sync2_q.rs | (state_q == ST_UNINIT);
`else
        err_d = 1'b1;
`endif
      end else if (state_q == ST_UNINIT) begin
        if (!sync2_q.rs && (op_s == OP_FUNC) && sync2_q.data[FUNC_DL_BIT]) begin
          state_d = ST_READY;
        end else begin
          err_d = 1'b1;
        end
      end else if (state_q != ST_READY) begin
        // Busy: drop the write; the running countdown is left untouched.
        err_d = 1'b1;
      end else if (sync2_q.rs) begin
        state_d  = ST_BUSY;
        cnt_d    = CMD_LOAD;
        mem_we_s = 1'b1;
        strobe_d = 1'b1;
        cursor_d = cursor_step_s;
      end else begin
        state_d = ST_BUSY;
        cnt_d   = CMD_LOAD;
        case (op_s)
          OP_DDRAM: cursor_d = sync2_q.data[AW-1:0];
          OP_FUNC: begin
            if (!sync2_q.data[FUNC_DL_BIT]) begin
              // 4-bit mode is rejected outright: no busy period either.
              state_d = ST_READY;
              cnt_d   = cnt_q;
              err_d   = 1'b1;
            end else begin
              err_d = 1'b0;
            end
          end
          OP_SHIFT: begin
            if (!sync2_q.data[3]) begin
              cursor_d = sync2_q.data[2] ? (cursor_q + ONE_A) : (cursor_q - ONE_A);
            end else begin
              cursor_d = cursor_q;
            end
          end
          OP_DISPLAY: disp_d = sync2_q.data[2];
          OP_ENTRY:   incr_d = sync2_q.data[1];
          OP_HOME:    cursor_d = '0;
          OP_CLEAR: begin
            state_d  = ST_CLEAR;
            cnt_d    = CLEAR_LOAD;
            fill_d   = '0;
            cursor_d = '0;
            incr_d   = 1'b1;
          end
          default: begin
            // CGRAM address and no-op: accepted, only the busy period.
            cursor_d = cursor_q;
          end
        endcase
      end
    end else begin
      err_d = 1'b0;
    end

    busy_d = (state_d == ST_BUSY) || (state_d == ST_CLEAR);
  end

  // Responder state and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_UNINIT;
      cnt_q    <= '0;
      fill_q   <= '0;
      cursor_q <= '0;
      incr_q   <= 1'b1;
      disp_q   <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      cursor_q <= cursor_d;
      incr_q   <= incr_d;
      disp_q   <= disp_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

`ifdef LCD_READ_EN
  logic       oe_d, oe_q;
  logic [7:0] dout_d, dout_q;

  // Read-back drive: computed from stage 1 so the registered enable lines
  // up with the synchronised en level.
  always_comb begin
    oe_d = sync1_q.en & sync1_q.rw & ~sync1_q.rs;
    if (oe_d) begin
      dout_d         = {1'b0, 7'(cursor_q)};
      dout_d[BF_BIT] = busy_q;
    end else begin
      dout_d = 8'h00;
    end
  end

  // Read-back output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe_q   <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      oe_q   <= oe_d;
      dout_q <= dout_d;
    end
  end

  assign lcd_data_oe  = oe_q;
  assign lcd_data_out = dout_q;
`else
  assign lcd_data_oe  = 1'b0;
  assign lcd_data_out = 8'h00;
`endif

  lcd_ddram #(.DEPTH(DDRAM_DEPTH), .AW(AW)) u_ddram (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (mem_wdata_s),
    .raddr (rd_addr),
    .rdata (rd_char)
  );

  assign busy         = busy_q;
  assign display_on   = disp_q;
  assign cursor_addr  = cursor_q;
  assign write_strobe = strobe_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Scoreboard bench for lcd_hd44780_responder: a behavioural model predicts
// each transaction's outcome (data accepted / rejected) into a queue; a
// monitor pops and compares on every write_strobe / protocol_err pulse.
// End-of-phase checks compare cursor, display flag and DDRAM contents.
`timescale 1ns/1ps
module tb_lcd_hd44780_responder;

  localparam int DEPTH = 32;
  localparam int CMD   = 40;
  localparam int CLR   = 1500;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic       busy, display_on;
  logic [4:0] cursor_addr;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic       write_strobe, protocol_err;

  lcd_hd44780_responder #(
    .DDRAM_DEPTH(DEPTH), .CMD_BUSY_CYCLES(CMD), .CLEAR_BUSY_CYCLES(CLR)
  ) dut (
    .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .busy(busy), .display_on(display_on), .cursor_addr(cursor_addr),
    .rd_addr(rd_addr), .rd_char(rd_char), .write_strobe(write_strobe),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;
  int strobe_cnt = 0;

  typedef struct { bit is_err; int cursor; } ev_t;
  ev_t exp_q[$];

  // Behavioural model of the display controller.
  bit         m_init;
  int         m_cursor;
  bit         m_incr, m_disp;
  logic [7:0] m_mem [DEPTH];
  int         m_busy_end;
  bit         m_last_acc, m_last_clr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int msb(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) if (d[i]) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_init = 1'b0; m_cursor = 0; m_incr = 1'b1; m_disp = 1'b0;
    m_busy_end = 0; m_last_acc = 1'b0; m_last_clr = 1'b0;
    exp_q.delete();
  endfunction

  // Predict one transaction arriving (en falling) at cycle t.
  function automatic void model_xact(input bit rs, input bit rw, input logic [7:0] d, input int t);
    bit err = 1'b0;
    ev_t ev;
    m_last_acc = 1'b0;
    m_last_clr = 1'b0;
    if (rw) begin
`ifdef LCD_READ_EN
      err = rs || !m_init;
`else
      err = 1'b1;
`endif
    end else if (!m_init) begin
      if (!rs && msb(d) == 5 && d[4]) m_init = 1'b1;
      else err = 1'b1;
    end else if (t < m_busy_end) begin
      err = 1'b1;
    end else if (rs) begin
      m_mem[m_cursor] = d;
      m_cursor = (m_cursor + (m_incr ? 1 : DEPTH - 1)) % DEPTH;
      m_busy_end = t + CMD + 1;
      m_last_acc = 1'b1;
      ev.is_err = 1'b0; ev.cursor = m_cursor;
      exp_q.push_back(ev);
    end else begin
      m_last_acc = 1'b1;
      m_busy_end = t + CMD + 1;
      case (msb(d))
        7: m_cursor = int'(d) % DEPTH;
        5: if (!d[4]) begin err = 1'b1; m_last_acc = 1'b0; m_busy_end = t; end
        4: if (!d[3]) m_cursor = (m_cursor + (d[2] ? 1 : DEPTH - 1)) % DEPTH;
        3: m_disp = d[2];
        2: m_incr = d[1];
        1: m_cursor = 0;
        0: begin
          for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h20;
          m_cursor = 0; m_incr = 1'b1; m_busy_end = t + CLR + 1; m_last_clr = 1'b1;
        end
        default: ;
      endcase
    end
    if (err) begin
      ev.is_err = 1'b1; ev.cursor = m_cursor;
      exp_q.push_back(ev);
    end
  endfunction

  // Monitor: every strobe or error pulse must match the next prediction.
  always @(negedge clk) begin
    if (reset === 1'b0 && (write_strobe === 1'b1 || protocol_err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_event: strobe=%0b err=%0b, none expected (cycle %0d)",
                 write_strobe, protocol_err, cyc);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        check("event_is_err", {31'd0, protocol_err}, {31'd0, ev.is_err});
        check("event_strobe", {31'd0, write_strobe}, {31'd0, !ev.is_err});
        check("event_cursor", {27'd0, cursor_addr}, ev.cursor);
        if (write_strobe === 1'b1) strobe_cnt++;
      end
    end
  end

  // One bus transaction: en high 4 cycles, bus held 3 cycles after the fall.
  task automatic xact(input bit rs, input bit rw, input logic [7:0] d, input int gap);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1'b1;
    repeat (4) @(negedge clk);
`ifdef LCD_READ_EN
    if (rw) check("oe_during_read", {31'd0, lcd_data_oe}, {31'd0, !rs});
`else
    if (rw) check("oe_during_read", {31'd0, lcd_data_oe}, 32'd0);
`endif
    lcd_en = 1'b0;
    model_xact(rs, rw, d, cyc);
    repeat (3) @(negedge clk);
    if (rw) check("oe_after_read", {31'd0, lcd_data_oe}, 32'd0);
    lcd_rw = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rd_check(input int a, input logic [7:0] exp, input string nm);
    @(negedge clk); rd_addr = a[4:0];
    @(negedge clk); check(nm, {24'd0, rd_char}, {24'd0, exp});
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  logic [7:0] word [7];
  int         s0;
  logic [7:0] rb;
  int         r, gap;
  bit         prev_short;
  bit         seen;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_en = 1'b0; lcd_data_in = 8'h00; rd_addr = 5'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_display_on", {31'd0, display_on}, 32'd0);
    check("rst_cursor", {27'd0, cursor_addr}, 32'd0);
    check("rst_oe", {31'd0, lcd_data_oe}, 32'd0);
    check("rst_data_out", {24'd0, lcd_data_out}, 32'd0);
    check("rst_strobe", {31'd0, write_strobe}, 32'd0);
    check("rst_err", {31'd0, protocol_err}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Before initialisation everything except function-set DL=1 is rejected.
    xact(1'b1, 1'b0, 8'h41, 20);
    xact(1'b1, 1'b0, 8'h42, 20);
    xact(1'b0, 1'b0, 8'h28, 20);

    // Init sequence.
    xact(1'b0, 1'b0, 8'h38, 2000);
    xact(1'b0, 1'b0, 8'h0C, 2000);
    xact(1'b0, 1'b0, 8'h01, 2000);
    xact(1'b0, 1'b0, 8'h06, 2000);
    check("init_display_on", {31'd0, display_on}, 32'd1);
    check("init_cursor", {27'd0, cursor_addr}, 32'd0);
    check("init_busy", {31'd0, busy}, 32'd0);
    for (int a = 0; a < DEPTH; a++) rd_check(a, 8'h20, "init_blank");

    // Text write.
    word[0] = 8'h57; word[1] = 8'h41; word[2] = 8'h53; word[3] = 8'h48;
    word[4] = 8'h49; word[5] = 8'h4E; word[6] = 8'h5A;
    s0 = strobe_cnt;
    for (int i = 0; i < 7; i++) xact(1'b1, 1'b0, word[i], 100);
    for (int i = 0; i < 7; i++) rd_check(i, word[i], "text_char");
    check("text_cursor", {27'd0, cursor_addr}, 32'd7);
    check("text_strobes", strobe_cnt - s0, 32'd7);

    // Wrap from the last address.
    xact(1'b0, 1'b0, 8'h9F, 100);
    xact(1'b1, 1'b0, 8'h41, 100);
    xact(1'b1, 1'b0, 8'h42, 100);
    rd_check(31, 8'h41, "wrap_last");
    rd_check(0, 8'h42, "wrap_first");
    check("wrap_cursor", {27'd0, cursor_addr}, 32'd1);

    // Write during busy is dropped.
    xact(1'b1, 1'b0, 8'h43, 5);
    xact(1'b1, 1'b0, 8'h44, 100);
    rd_check(1, 8'h43, "busy_first_kept");
    rd_check(2, 8'h53, "busy_second_dropped");
    check("busy_cursor", {27'd0, cursor_addr}, 32'd2);

    // Status read shortly after a data write at address 4.
    xact(1'b0, 1'b0, 8'h84, 100);
    xact(1'b1, 1'b0, 8'h45, 0);
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_en = 1'b1;
    repeat (3) @(negedge clk);
`ifdef LCD_READ_EN
    check("read_oe", {31'd0, lcd_data_oe}, 32'd1);
    check("read_data", {24'd0, lcd_data_out}, 32'h85);
`else
    check("read_oe", {31'd0, lcd_data_oe}, 32'd0);
    check("read_data", {24'd0, lcd_data_out}, 32'd0);
`endif
    lcd_en = 1'b0;
    model_xact(1'b0, 1'b1, 8'h00, cyc);
    repeat (3) @(negedge clk);
    check("read_oe_low", {31'd0, lcd_data_oe}, 32'd0);
    lcd_rw = 1'b0;
    repeat (100) @(negedge clk);

    // Randomised traffic against the model.
    prev_short = 1'b0;
    for (int n = 0; n < 80; n++) begin
      bit rs = 1'b0, rw = 1'b0;
      logic [7:0] d;
      r = $urandom_range(0, 23);
      if (r <= 7)       begin rs = 1'b1; d = 8'($urandom_range(32, 126)); end
      else if (r <= 9)  d = 8'h80 | 8'($urandom_range(0, 127));
      else if (r == 10) d = 8'h40 | 8'($urandom_range(0, 63));
      else if (r == 11) d = 8'h30 | 8'($urandom_range(0, 15));
      else if (r == 12) d = 8'h20 | 8'($urandom_range(0, 15));
      else if (r <= 14) d = 8'h10 | 8'($urandom_range(0, 15));
      else if (r == 15) d = 8'h08 | 8'($urandom_range(0, 7));
      else if (r <= 17) d = 8'h04 | 8'($urandom_range(0, 3));
      else if (r == 18) d = 8'h02 | 8'($urandom_range(0, 1));
      else if (r == 19) d = 8'h01;
      else if (r == 20) d = 8'h00;
      else if (r <= 22) begin rw = 1'b1; d = 8'h00; end
      else              begin rw = 1'b1; rs = 1'b1; d = 8'h00; end
      // Gap chosen after prediction so arrivals stay clear of busy boundaries.
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1'b1;
      repeat (4) @(negedge clk);
      lcd_en = 1'b0;
      model_xact(rs, rw, d, cyc);
      repeat (3) @(negedge clk);
      lcd_rw = 1'b0;
      if (m_last_clr) begin gap = 1600; prev_short = 1'b0; end
      else if (m_last_acc && !prev_short && $urandom_range(0, 3) == 0) begin gap = 5; prev_short = 1'b1; end
      else begin gap = 60; prev_short = 1'b0; end
      repeat (gap) @(negedge clk);
    end
    repeat (1700) @(negedge clk);
    check("rand_busy", {31'd0, busy}, 32'd0);
    check("rand_cursor", {27'd0, cursor_addr}, m_cursor);
    check("rand_display_on", {31'd0, display_on}, {31'd0, m_disp});
    for (int a = 0; a < DEPTH; a++) rd_check(a, m_mem[a], "rand_ddram");
    check("rand_queue_drained", exp_q.size(), 32'd0);

    // Reset in the middle of a clear.
    do_reset();
    xact(1'b0, 1'b0, 8'h38, 60);
    xact(1'b0, 1'b0, 8'h01, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check("clear_busy_seen", {31'd0, seen}, 32'd1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_cursor", {27'd0, cursor_addr}, 32'd0);
    model_reset();
    reset = 1'b0;
    xact(1'b1, 1'b0, 8'h41, 20);
    check("abort_queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
